s1423_n95_capture: RTL and testbench
====================================

Name: s1423_n95_capture

Overview:
- Sequential harness stage that drives the 31 pseudo-primary inputs of the combinational s1423 n95 cone and captures its output.
- Loads an input vector serially through a scan chain, waits a programmable settle window, then registers n95.
- Compares the captured bit against an expected value and keeps a saturating mismatch count.
- Sits directly around the cone: its vector feeds the cone and it consumes n95, restoring the flip-flop boundary that the combinational conversion removed.

Parameters:
- VEC_W, 31, number of cone inputs / scan chain length.
- SETTLE_CYCLES, 1, cycles between the end of the shift and capture (legal range 1..15).
- CNT_W, 8, width of the mismatch counter.

Ports:
- CK  in  1  clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- start  in  1  begin a load/capture sequence; sampled only in IDLE.
- expected  in  1  golden n95 value; latched on an accepted start.
- scan_in  in  1  serial vector data, one bit per SHIFT cycle.
- n95  in  1  output of the cone.
- cone_vec  out  VEC_W  cone inputs; bit order G1,G2,G3,G4,G8,G32,G14,G31,G30,G29,G92,G28,G27,G24,G25,G26,G46,G90,G45,G84,G78,G85,G44,G64,G77,G76,G43,G42,G0,G75,G74 = bits 0..30.
- scan_out  out  1  cone_vec[0], the previous vector shifted out.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse in the DONE state.
- capture_q  out  1  registered n95.
- mismatch  out  1  capture_q != latched expected; valid from DONE until the next capture.
- mismatch_cnt  out  CNT_W  saturating count of mismatching captures.

Behaviour:
- Reset (asynchronous):
  - state goes to IDLE.
  - cone_vec, capture_q, mismatch, mismatch_cnt, done, the expected latch and all counters go to 0.
  - Reset asserted mid-sequence aborts it immediately. No done pulse and no counter update occur.
- States: IDLE, SHIFT, SETTLE, CAPTURE, DONE.
- IDLE:
  - start=1 latches expected and clears the bit counter, then moves to SHIFT.
  - start=0 stays in IDLE. cone_vec holds its value.
- SHIFT:
  - Each cycle: cone_vec <= {scan_in, cone_vec[VEC_W-1:1]}, and the bit counter increments.
  - After exactly VEC_W shift cycles, move to SETTLE. The first bit shifted in ends up in bit 0.
- SETTLE:
  - cone_vec is frozen.
  - Stay for SETTLE_CYCLES cycles, then move to CAPTURE.
- CAPTURE (one cycle):
  - capture_q <= n95.
  - mismatch <= (n95 != expected_latched).
  - If mismatching and mismatch_cnt < 2^CNT_W-1, increment mismatch_cnt. It saturates at all-ones with no wrap.
- DONE (one cycle): done=1, then return to IDLE.
- start is ignored while busy=1, so there is no queuing. A start in the same cycle as the DONE-to-IDLE return is ignored. start is accepted in IDLE on the following cycle.
- Latency: an accepted start produces done exactly VEC_W+SETTLE_CYCLES+2 cycles later (34 for the defaults).
- cone_vec changes only in SHIFT, so the cone input is stable for the whole settle and capture window.
- All outputs are registered except busy and scan_out, which are decoded from registered state.

Decomposition:
- Shared package s1423_pkg holds:
  - the state enum;
  - the VEC_W default;
  - localparams giving the bit index of each cone input (for example IDX_G32=5, IDX_G14=6, IDX_G31=7).
- Sub-module s1423_scan_reg: a VEC_W-bit shift register with shift enable, async reset and parallel output.
- The FSM, counters and compare logic stay in the top module.

Test Plan:
- Reset mid-SHIFT (after 10 bits) -> busy=0 and cone_vec=0 next cycle, no done, mismatch_cnt unchanged at 0.
- Shift vector 0x00000060 (G32=1, G14=1, others 0) with the cone instantiated, expected=1 -> done at start+34, capture_q=1, mismatch=0, mismatch_cnt=0.
- Shift vector 0x00000040 (G14=1, G32=0), expected=1 -> capture_q=0, mismatch=1, mismatch_cnt=1.
- Run back-to-back sequences with start held high continuously -> each done is followed by one IDLE cycle before the next SHIFT. The starts seen during busy cause no extra sequence.
- Run 256 consecutive mismatching captures with CNT_W=8 -> mismatch_cnt=255, stays 255 and does not wrap.
- Shift 0x12345678 and then any second vector -> during the second SHIFT, scan_out emits 0x12345678 LSB-first over 31 cycles.

Source files
------------

// File: rtl/s1423_pkg.sv
// Shared types and constants for the s1423 n95 capture harness.
// Bit positions of each cone input within the scan vector.
package s1423_pkg;

    localparam int VEC_W_DEF = 31;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SHIFT   = 3'd1,
        S_SETTLE  = 3'd2,
        S_CAPTURE = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam int IDX_G1  = 0;
    localparam int IDX_G2  = 1;
    localparam int IDX_G3  = 2;
    localparam int IDX_G4  = 3;
    localparam int IDX_G8  = 4;
    localparam int IDX_G32 = 5;
    localparam int IDX_G14 = 6;
    localparam int IDX_G31 = 7;
    localparam int IDX_G30 = 8;
    localparam int IDX_G29 = 9;
    localparam int IDX_G92 = 10;
    localparam int IDX_G28 = 11;
    localparam int IDX_G27 = 12;
    localparam int IDX_G24 = 13;
    localparam int IDX_G25 = 14;
    localparam int IDX_G26 = 15;
    localparam int IDX_G46 = 16;
    localparam int IDX_G90 = 17;
    localparam int IDX_G45 = 18;
    localparam int IDX_G84 = 19;
    localparam int IDX_G78 = 20;
    localparam int IDX_G85 = 21;
    localparam int IDX_G44 = 22;
    localparam int IDX_G64 = 23;
    localparam int IDX_G77 = 24;
    localparam int IDX_G76 = 25;
    localparam int IDX_G43 = 26;
    localparam int IDX_G42 = 27;
    localparam int IDX_G0  = 28;
    localparam int IDX_G75 = 29;
    localparam int IDX_G74 = 30;

endpackage

// File: rtl/s1423_scan_reg.sv
// Serial-in, parallel-out shift register feeding the cone inputs.
// New bits enter at the MSB so the first bit shifted ends up in bit 0.
module s1423_scan_reg #(
    parameter int W = 31
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         shift_en,
    input  logic         sin,
    output logic [W-1:0] q
);

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {sin, q[W-1:1]};
        end
    end

endmodule

// File: rtl/s1423_n95_capture.sv
// Load/settle/capture harness around the s1423 n95 cone with a
// saturating mismatch counter against a latched golden value.
//
// state     | meaning
// ----------+-------------------------------------------------
// S_IDLE    | waiting for start; cone_vec held
// S_SHIFT   | shifting VEC_W bits from scan_in into cone_vec
// S_SETTLE  | cone_vec frozen for SETTLE_CYCLES cycles
// S_CAPTURE | register n95, compare, update mismatch count
// S_DONE    | one-cycle done pulse, then back to idle
module s1423_n95_capture
    import s1423_pkg::*;
#(
    parameter int VEC_W         = VEC_W_DEF,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             start,
    input  logic             expected,
    input  logic             scan_in,
    input  logic             n95,
    output logic [VEC_W-1:0] cone_vec,
    output logic             scan_out,
    output logic             busy,
    output logic             done,
    output logic             capture_q,
    output logic             mismatch,
    output logic [CNT_W-1:0] mismatch_cnt
);

    localparam int BCNT_W = $clog2(VEC_W);
    localparam logic [BCNT_W-1:0] BIT_LAST    = BCNT_W'(VEC_W - 1);
    localparam logic [3:0]        SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic              shift_en;
    logic [BCNT_W-1:0] bit_cnt;
    logic [3:0]        settle_cnt;
    logic              exp_q;

    s1423_scan_reg #(.W(VEC_W)) u_scan (
        .CK       (CK),
        .RST      (RST),
        .shift_en (shift_en),
        .sin      (scan_in),
        .q        (cone_vec)
    );

    assign scan_out = cone_vec[0];
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        shift_en  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == BIT_LAST) state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (settle_cnt == 4'd0) state_nxt = S_CAPTURE;
            end
            S_CAPTURE: state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            bit_cnt      <= '0;
            settle_cnt   <= '0;
            exp_q        <= 1'b0;
            capture_q    <= 1'b0;
            mismatch     <= 1'b0;
            mismatch_cnt <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state_nxt == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        exp_q   <= expected;
                        bit_cnt <= '0;
                    end
                end
                S_SHIFT: begin
                    bit_cnt <= bit_cnt + 1'b1;
                    if (state_nxt == S_SETTLE) settle_cnt <= SETTLE_LOAD;
                end
                S_SETTLE: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 1'b1;
                end
                S_CAPTURE: begin
                    capture_q <= n95;
                    mismatch  <= (n95 != exp_q);
                    // saturate at all-ones rather than wrapping
                    if ((n95 != exp_q) && (mismatch_cnt != {CNT_W{1'b1}}))
                        mismatch_cnt <= mismatch_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_s1423_n95_capture.sv
// Directed bench for s1423_n95_capture; n95 comes from a stand-in cone
// (G32 & G14) so the hand-picked vectors give known capture values.
module tb_s1423_n95_capture;
    import s1423_pkg::*;

    logic        CK = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0;
    logic        expected = 1'b0;
    logic        scan_in = 1'b0;
    logic        n95;
    logic [30:0] cone_vec;
    logic        scan_out, busy, done, capture_q, mismatch;
    logic [7:0]  mismatch_cnt;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  cnt_m = 8'd0;

    always #5 CK = ~CK;

    assign n95 = cone_vec[IDX_G32] & cone_vec[IDX_G14];

    s1423_n95_capture #(.VEC_W(31), .SETTLE_CYCLES(1), .CNT_W(8)) dut (
        .CK           (CK),
        .RST          (RST),
        .start        (start),
        .expected     (expected),
        .scan_in      (scan_in),
        .n95          (n95),
        .cone_vec     (cone_vec),
        .scan_out     (scan_out),
        .busy         (busy),
        .done         (done),
        .capture_q    (capture_q),
        .mismatch     (mismatch),
        .mismatch_cnt (mismatch_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full sequence; the accepting IDLE cycle is cycle 0, done must be seen in cycle 34.
    task automatic run_seq(input logic [30:0] vec, input logic e,
                           input logic [30:0] prev, input bit chk_scan);
        int   lat;
        logic m;
        @(negedge CK);
        start    = 1'b1;
        expected = e;
        for (int i = 0; i < 31; i++) begin
            @(negedge CK);
            if (i == 0) begin
                start    = 1'b0;
                expected = ~e;
                chk("busy_shift", 32'(busy), 1);
            end
            if (chk_scan) chk("scan_out", 32'(scan_out), 32'(prev[i]));
            scan_in = vec[i];
        end
        @(negedge CK);
        chk("vec_settle", 32'(cone_vec), 32'(vec));
        chk("done_early", 32'(done), 0);
        lat = 999;
        for (int c = 33; c <= 40; c++) begin
            @(negedge CK);
            if (done) begin
                lat = c;
                break;
            end
        end
        chk("latency", 32'(lat), 34);
        m = ((vec[IDX_G32] & vec[IDX_G14]) != e);
        if (m && cnt_m != 8'hFF) cnt_m++;
        chk("capture_q", 32'(capture_q), 32'(vec[IDX_G32] & vec[IDX_G14]));
        chk("mismatch", 32'(mismatch), 32'(m));
        chk("mismatch_cnt", 32'(mismatch_cnt), 32'(cnt_m));
        chk("vec_done", 32'(cone_vec), 32'(vec));
        @(negedge CK);
        chk("done_pulse", 32'(done), 0);
        chk("idle_after", 32'(busy), 0);
    endtask

    initial begin
        int cyc;

        // reset values
        @(negedge CK);
        @(negedge CK);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_vec", 32'(cone_vec), 0);
        chk("rst_cap", 32'(capture_q), 0);
        chk("rst_mm", 32'(mismatch), 0);
        chk("rst_cnt", 32'(mismatch_cnt), 0);
        RST = 1'b0;

        // reset mid-SHIFT after 10 ones
        @(negedge CK);
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge CK);
            start   = 1'b0;
            scan_in = 1'b1;
        end
        @(negedge CK);
        chk("part_vec", 32'(cone_vec), 32'h7FE0_0000);
        RST = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_vec", 32'(cone_vec), 0);
        @(negedge CK);
        RST     = 1'b0;
        scan_in = 1'b0;
        chk("abort_done", 32'(done), 0);
        chk("abort_cnt", 32'(mismatch_cnt), 0);
        @(negedge CK);
        chk("abort_idle", 32'(busy), 0);
        chk("abort_vec2", 32'(cone_vec), 0);

        // matching and mismatching captures
        run_seq(31'h0000_0060, 1'b1, 31'h0, 1'b0);
        run_seq(31'h0000_0040, 1'b1, 31'h0, 1'b0);

        // start held high: DONE, one IDLE cycle, then SHIFT; period 35
        @(negedge CK);
        start    = 1'b1;
        expected = 1'b0;
        scan_in  = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 50; c++) begin
            @(negedge CK);
            if (done) begin
                cyc = c;
                break;
            end
        end
        chk("b2b_lat1", 32'(cyc), 34);
        @(negedge CK);
        chk("b2b_idle", 32'(busy), 0);
        chk("b2b_done_lo", 32'(done), 0);
        @(negedge CK);
        chk("b2b_shift", 32'(busy), 1);
        cyc = 0;
        for (int c = 3; c <= 50; c++) begin
            @(negedge CK);
            if (done) begin
                cyc = c;
                break;
            end
        end
        chk("b2b_period", 32'(cyc), 35);
        chk("b2b_cnt", 32'(mismatch_cnt), 32'(cnt_m));
        chk("b2b_mm", 32'(mismatch), 0);
        @(negedge CK);
        start = 1'b0;
        chk("b2b_idle2", 32'(busy), 0);
        @(negedge CK);
        chk("b2b_stop", 32'(busy), 0);

        // previous vector emerges on scan_out LSB-first
        run_seq(31'h1234_5678, 1'b1, 31'h0, 1'b0);
        run_seq(31'h0000_0040, 1'b1, 31'h1234_5678, 1'b1);

        // saturation of the mismatch counter
        for (int k = 0; k < 256; k++) begin
            run_seq(31'h0000_0040, 1'b1, 31'h0000_0040, 1'b0);
        end
        chk("sat_final", 32'(mismatch_cnt), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
